// File: rtl/serial_pad_pkg.sv
// Shared types and helpers for the serial game-pad port emulation.
package serial_pad_pkg;

   localparam int         MAX_CHANNELS = 4;
   localparam logic [7:0] KEY_IDLE     = 8'hFF;

   typedef enum logic {
      KEY_IDLE_S,
      KEY_HELD_S
   } key_state_t;

   function automatic logic [7:0] bitrev8(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) begin
         r[i] = v[7-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/serial_pad_shifter.sv
// One serial pad port: level-sensitive parallel load while latched, one shift per pulse rising edge.
// data is the register LSB; a shift appears on the clock that samples the edge.
module serial_pad_shifter #(
   parameter int   WIDTH    = 8,
   parameter logic FILL_BIT = 1'b1
) (
   input  logic             clk_app,
   input  logic             reset,
   input  logic [WIDTH-1:0] load_word,
   input  logic             latch,
   input  logic             pulse,
   output logic             data
);

   logic [WIDTH-1:0] sreg;
   logic             pulse_q;

   // pulse_q tracks the pin even while latched, so a pulse held across the latch fall is not an edge
   always_ff @(posedge clk_app or posedge reset) begin
      if (reset) begin
         sreg    <= '1;
         pulse_q <= 1'b0;
      end else begin
         pulse_q <= pulse;
         if (latch) begin
            sreg <= load_word;
         end else if (pulse && !pulse_q) begin
            sreg <= {FILL_BIT, sreg[WIDTH-1:1]};
         end
      end
   end

   assign data = sreg[0];

endmodule

// File: rtl/serial_pad_emu.sv
// Famicom/NES (8-bit) or SNES (16-bit) serial pad emulation, CHANNELS ports on a shared latch.
// With SERIAL_PAD_KEY_MERGE_EN defined, a strobed ASCII key is folded into port 0 for KEY_HOLD frames.
module serial_pad_emu
   import serial_pad_pkg::*;
#(
   parameter int   CHANNELS = 1,
   parameter int   WIDTH    = 8,
   parameter logic FILL_BIT = 1'b1,
   parameter int   KEY_HOLD = 2
) (
   input  logic                      clk_app,
   input  logic                      reset,
   input  logic [CHANNELS*WIDTH-1:0] pad_buttons,
   input  logic                      pad_latch,
   input  logic [CHANNELS-1:0]       pad_pulse,
   output logic [CHANNELS-1:0]       pad_data,
   input  logic                      key_strobe,
   input  logic [7:0]                key_code,
   output logic                      key_active
);

   if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
      $error("serial_pad_emu: CHANNELS out of range");
   end

   logic [7:0] key_field;

`ifdef SERIAL_PAD_KEY_MERGE_EN
   localparam int               CNT_W     = $clog2(KEY_HOLD + 1);
   localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(KEY_HOLD);

   key_state_t       state, state_nxt;
   logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
   logic [7:0]       held_code, held_code_nxt;
   logic             latch_q;
   logic             latch_fall;

   assign latch_fall = latch_q & ~pad_latch;

   always_ff @(posedge clk_app or posedge reset) begin
      if (reset) begin
         state     <= KEY_IDLE_S;
         hold_cnt  <= '0;
         held_code <= '0;
         latch_q   <= 1'b0;
      end else begin
         state     <= state_nxt;
         hold_cnt  <= hold_cnt_nxt;
         held_code <= held_code_nxt;
         latch_q   <= pad_latch;
      end
   end

   // A strobe coinciding with a frame end restarts the hold rather than consuming a frame
   always_comb begin
      state_nxt     = state;
      hold_cnt_nxt  = hold_cnt;
      held_code_nxt = held_code;
      if (key_strobe) begin
         state_nxt     = KEY_HELD_S;
         hold_cnt_nxt  = HOLD_INIT;
         held_code_nxt = key_code;
      end else if (state == KEY_HELD_S && latch_fall) begin
         hold_cnt_nxt = hold_cnt - 1'b1;
         if (hold_cnt_nxt == '0) begin
            state_nxt = KEY_IDLE_S;
         end
      end
   end

   always_comb begin
      key_active = (state == KEY_HELD_S);
      key_field  = key_active ? bitrev8(held_code) : KEY_IDLE;
   end
`else
   logic unused_key;
   assign unused_key = key_strobe ^ (^key_code) ^ (KEY_HOLD > 0);
   assign key_active = 1'b0;
   assign key_field  = KEY_IDLE;
`endif

   // Key only touches the low byte; SNES high byte comes from the pad alone
   logic [WIDTH-1:0] key_mask;
   always_comb begin
      key_mask      = '1;
      key_mask[7:0] = key_field;
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [WIDTH-1:0] word;
      if (c == 0) begin : g_merge
         assign word = ~pad_buttons[c*WIDTH +: WIDTH] & key_mask;
      end else begin : g_plain
         assign word = ~pad_buttons[c*WIDTH +: WIDTH];
      end

      serial_pad_shifter #(
         .WIDTH    (WIDTH),
         .FILL_BIT (FILL_BIT)
      ) u_shifter (
         .clk_app   (clk_app),
         .reset     (reset),
         .load_word (word),
         .latch     (pad_latch),
         .pulse     (pad_pulse[c]),
         .data      (pad_data[c])
      );
   end

endmodule

// File: tb/tb_serial_pad_emu.sv
// Scoreboarded bench for serial_pad_emu: one 8-bit single-port instance and one 16-bit two-port instance.
module tb_serial_pad_emu;

   logic clk_app = 1'b0;
   logic reset   = 1'b1;
   always #5 clk_app = ~clk_app;

   logic [7:0]  a_buttons;
   logic        a_latch;
   logic [0:0]  a_pulse;
   logic [0:0]  a_data;
   logic        key_strobe;
   logic [7:0]  key_code;
   logic        key_active;

   logic [31:0] b_buttons;
   logic        b_latch;
   logic [1:0]  b_pulse;
   logic [1:0]  b_data;
   logic        b_key_active;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;
   exp_t sb_q[$];

   serial_pad_emu #(
      .CHANNELS (1), .WIDTH (8), .FILL_BIT (1'b1), .KEY_HOLD (2)
   ) dut_a (
      .clk_app     (clk_app),
      .reset       (reset),
      .pad_buttons (a_buttons),
      .pad_latch   (a_latch),
      .pad_pulse   (a_pulse),
      .pad_data    (a_data),
      .key_strobe  (key_strobe),
      .key_code    (key_code),
      .key_active  (key_active)
   );

   serial_pad_emu #(
      .CHANNELS (2), .WIDTH (16), .FILL_BIT (1'b0), .KEY_HOLD (2)
   ) dut_b (
      .clk_app     (clk_app),
      .reset       (reset),
      .pad_buttons (b_buttons),
      .pad_latch   (b_latch),
      .pad_pulse   (b_pulse),
      .pad_data    (b_data),
      .key_strobe  (1'b0),
      .key_code    (8'h00),
      .key_active  (b_key_active)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb_q.push_back(e);
   endtask

   task automatic sb_compare(input logic [31:0] got);
      exp_t e;
      if (sb_q.size() == 0) begin
         chk("sb_underflow", sb_q.size(), 1);
      end else begin
         e = sb_q.pop_front();
         chk(e.tag, got, e.val);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk_app);
   endtask

   function automatic logic [7:0] rev8(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = v[7-i];
      return r;
   endfunction

   task automatic frame_a(input logic [7:0] btn);
      a_buttons = btn;
      a_latch   = 1'b1;
      tick(2);
      a_latch   = 1'b0;
      tick();
   endtask

   task automatic pulse_a();
      a_pulse = 1'b1;
      tick();
      a_pulse = 1'b0;
      tick();
   endtask

   // word is the active-low serial word; bits past 8 read the fill value 1
   task automatic run_a(input string tag, input logic [7:0] word, input int n);
      for (int k = 0; k <= n; k++) begin
         sb_push($sformatf("%s[%0d]", tag, k), (k < 8) ? {31'b0, word[k]} : 32'd1);
      end
      for (int k = 0; k <= n; k++) begin
         sb_compare({31'b0, a_data});
         if (k < n) pulse_a();
      end
   endtask

   task automatic run_b(input logic [15:0] w1, input logic [15:0] w0, input int n);
      for (int k = 0; k <= n; k++) begin
         sb_push($sformatf("b_shift[%0d]", k), {30'b0, (k < 16) ? w1[k] : 1'b0, w0[0]});
      end
      for (int k = 0; k <= n; k++) begin
         sb_compare({30'b0, b_data});
         if (k < n) begin
            b_pulse = 2'b10;
            tick();
            b_pulse = 2'b00;
            tick();
         end
      end
   endtask

   initial begin
      a_buttons = '0; a_latch = 1'b0; a_pulse = '0;
      key_strobe = 1'b0; key_code = '0;
      b_buttons = '0; b_latch = 1'b0; b_pulse = '0;

      tick(2);
      chk("reset_a_data", {31'b0, a_data}, 32'd1);
      chk("reset_b_data", {30'b0, b_data}, 32'd3);
      chk("reset_key_active", {31'b0, key_active}, 32'd0);
      chk("reset_b_key_active", {31'b0, b_key_active}, 32'd0);
      reset = 1'b0;
      tick(2);
      chk("no_load_without_latch", {31'b0, a_data}, 32'd1);

      // Live tracking while latched: 1-cycle load latency
      a_buttons = 8'h00; a_latch = 1'b1;
      tick();
      chk("latched_idle", {31'b0, a_data}, 32'd1);
      a_buttons = 8'h81;
      tick();
      chk("load_latency", {31'b0, a_data}, 32'd0);
      a_latch = 1'b0;
      tick();
      run_a("nes_81", ~8'h81, 10);

      // 16-bit two-port: pulses on ch1 only
      b_buttons = {16'h8000, 16'h0002};
      b_latch = 1'b1;
      tick(2);
      b_latch = 1'b0;
      tick();
      run_b(~16'h8000, ~16'h0002, 17);

      // Pulse during latch and a long held pulse
      a_buttons = 8'h05; a_latch = 1'b1;
      tick();
      a_pulse = 1'b1;
      tick(3);
      chk("pulse_in_latch", {31'b0, a_data}, 32'd0);
      a_latch = 1'b0;
      tick(2);
      chk("no_edge_after_latch", {31'b0, a_data}, 32'd0);
      a_pulse = 1'b0;
      tick();
      a_pulse = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("held_pulse[%0d]", i), {31'b0, a_data}, 32'd1);
      end
      a_pulse = 1'b0;
      tick();
      pulse_a();
      chk("pulse_after_hold", {31'b0, a_data}, 32'd0);

      // Reset mid-word
      frame_a(8'h08);
      for (int i = 0; i < 3; i++) pulse_a();
      chk("before_reset", {31'b0, a_data}, 32'd0);
      reset = 1'b1;
      #1;
      chk("reset_async", {31'b0, a_data}, 32'd1);
      tick();
      reset = 1'b0;
      tick(2);
      chk("no_reload_after_reset", {31'b0, a_data}, 32'd1);
      frame_a(8'h08);
      run_a("reload_08", ~8'h08, 4);

`ifdef SERIAL_PAD_KEY_MERGE_EN
      key_code = 8'h41; key_strobe = 1'b1;
      tick();
      key_strobe = 1'b0;
      chk("key_active_set", {31'b0, key_active}, 32'd1);
      frame_a(8'h00);
      chk("key_active_frame1", {31'b0, key_active}, 32'd1);
      run_a("key41_f1", rev8(8'h41), 8);
      frame_a(8'h00);
      chk("key_active_frame2", {31'b0, key_active}, 32'd0);
      run_a("key41_f2", rev8(8'h41), 8);
      frame_a(8'h00);
      run_a("key_f3", 8'hFF, 8);

      key_code = 8'h41; key_strobe = 1'b1;
      tick();
      key_strobe = 1'b0;
      frame_a(8'h00);
      a_latch = 1'b1;
      tick(2);
      a_latch = 1'b0; key_code = 8'h5A; key_strobe = 1'b1;
      tick();
      key_strobe = 1'b0;
      chk("strobe_wins_active", {31'b0, key_active}, 32'd1);
      frame_a(8'h00);
      chk("reload_count", {31'b0, key_active}, 32'd1);
      run_a("key5a", rev8(8'h5A), 8);
      frame_a(8'h00);
      chk("reload_expire", {31'b0, key_active}, 32'd0);
`else
      key_code = 8'h41; key_strobe = 1'b1;
      tick();
      key_strobe = 1'b0;
      chk("key_active_off", {31'b0, key_active}, 32'd0);
      frame_a(8'h00);
      run_a("key_ignored", 8'hFF, 8);
`endif

      chk("sb_leftover", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_pad_emu.md
# serial_pad_emu

Parametrised emulation of Famicom/NES-style serial game-controller ports for the Gigatron shell, the successor to the fixed single-port 8-bit joypad shifter in the guest top level. It serves up to four ports in 8-bit (NES) or 16-bit (SNES) mode, each with its own pulse and data line and a shared latch. An optional keyboard path folds a held ASCII code into port 0. The block sits between the user-io joystick/keyboard outputs and the core's `famicom_latch`/`famicom_pulse`/`famicom_data` pins, clocked by the Gigatron application clock.

## Interface
- `CHANNELS`, default 1: number of ports, legal 1–4.
- `WIDTH`, default 8: serial word length, legal 8 or 16.
- `FILL_BIT`, default 1'b1: value shifted in behind the word, so reads past `WIDTH` bits return this value.
- `KEY_HOLD`, default 2: number of latch frames a captured key stays presented, legal ≥1.
- `clk_app`  in  1: application clock; every register is in this domain.
- `reset`  in  1: asynchronous, active-high.
- `pad_buttons`  in  CHANNELS*WIDTH: active-high pressed bits. Channel c occupies `[c*WIDTH +: WIDTH]`; bit 0 is shifted out first.
- `pad_latch`  in  1: shared latch from the core, level-sensitive.
- `pad_pulse`  in  CHANNELS: per-channel shift clock from the core.
- `pad_data`  out  CHANNELS: serial data, active-low (0 = pressed).
- `key_strobe`  in  1: one-cycle pulse marking a new key.
- `key_code`  in  8: ASCII code, sampled on `key_strobe`.
- `key_active`  out  1: high while a key is being presented.

## Operation
- Per channel, `sreg[WIDTH-1:0]`; `pad_data[c] = sreg_c[0]`, driven directly from the register.
- Load word per channel: `~pad_buttons_c`. Channel 0 with the key merge present uses `~pad_buttons_0 & {ones, key_field}`.
- `key_field` is `bitrev(held_code)` while `key_active`, otherwise 8'hFF. The key affects only bits [7:0]; in 16-bit mode bits [15:8] are the pad alone.
- While `pad_latch` is high: every channel reloads its load word each cycle, so the value tracks live inputs.
- While `pad_latch` is low and a rising edge of `pad_pulse[c]` is detected: `sreg_c <= {FILL_BIT, sreg_c[WIDTH-1:1]}`.
- Edge detection uses registered `pulse_q[c]`; an edge is `pad_pulse[c] & ~pulse_q[c]`.
- Priority per channel: reset > latch > shift > hold.
- Key state machine, states IDLE and HELD:
  - IDLE → HELD on `key_strobe`: capture `key_code`, `hold_cnt <= KEY_HOLD`.
  - In HELD, each falling edge of `pad_latch` (registered `latch_q`) decrements `hold_cnt`. Reaching 0 → IDLE.
  - `key_strobe` in HELD restarts: new code, counter reloaded.
  - `key_strobe` in the same cycle as a latch falling edge: the strobe wins and the counter is reloaded, not decremented.
- `key_active` = state is HELD.

## Timing
- Reset values:
  - `sreg` all ones, so `pad_data` = all ones.
  - `pulse_q` 0, `latch_q` 0.
  - Key state IDLE, `hold_cnt` 0, `held_code` 0, `key_active` 0.
- Load latency: a change on `pad_buttons` while latched appears on `pad_data` 1 cycle later.
- Shift latency: `pad_data` updates on the clock after the cycle in which the pulse edge is seen.
- A pulse held high is one edge only; no repeat shifts.
- After `WIDTH` edges `pad_data = FILL_BIT` and stays there until the next latch.
- A pulse edge while latch is high is ignored: the load wins and `pulse_q` still updates.
- A word is presented to the load path during the first latch after `key_strobe`, at the earliest 1 cycle later.
- Reset asserted mid-word: the register returns to all ones immediately. It reloads on the first latch after reset is released.

## Configuration
- `SERIAL_PAD_KEY_MERGE_EN`
  - Defined: key FSM, `held_code` and `hold_cnt` are compiled in; channel 0 merges `key_field` as described.
  - Undefined: the key logic is removed; `key_strobe` and `key_code` are ignored; `key_active` is tied to 0; channel 0 loads `~pad_buttons_0` only.

## Structure
- Package `serial_pad_pkg`:
  - constants `MAX_CHANNELS = 4`, `KEY_IDLE = 8'hFF`;
  - enum `key_state_t {KEY_IDLE_S, KEY_HELD_S}`;
  - function `bitrev8`.
- Sub-module `serial_pad_shifter`, one per channel via a generate loop.
  - Parameters: `WIDTH`, `FILL_BIT`.
  - Ports: `clk_app`, `reset`, `load_word`, `latch`, `pulse`, `data`.
- The top level holds the key FSM and the load-word muxing.

## Test plan
- Reset, CHANNELS=1, WIDTH=8, `pad_buttons`=8'h81: latch high 2 cycles then 10 pulses → `pad_data` sequence 0,1,1,1,1,1,1,0, then 1,1 (fill).
- WIDTH=16, CHANNELS=2, ch1 buttons 16'h8000: latch, then 16 pulses on ch1 only → ch1 bit 15 reads 0, all other bits 1; ch0 `pad_data` stays at 1 (its bit 0), unaffected by the ch1 pulses.
- Merge enabled, `key_strobe` with `key_code`=8'h41, no pad buttons: next frame shifts out 0x41 MSB-first (0,1,0,0,0,0,0,1) on ch0. With KEY_HOLD=2, frame 3 reads all ones and `key_active` falls after the 2nd latch falling edge.
- Pulse edge during latch high, and a pulse held high for 5 cycles → no shift, then exactly one shift.
- `key_strobe` coincident with a latch falling edge in HELD → counter reloads to KEY_HOLD and the new code is presented.
- Reset pulsed after 3 shifts → `pad_data`=1 within the same cycle; the next latch reloads the full word.
